// File: rtl/neuron_mac_ctrl.sv
// Sequential multiply-accumulate controller for a single neuron.
// One 5x5 signed multiplier is time-shared across N_INPUTS input/weight
// pairs. The bias seeds the accumulator, and the final sum is saturated to
// Q2.8 and can optionally be ReLU-clipped.

// 5-bit x 5-bit signed multiplier producing a full 10-bit signed product.
module twosmult (
  input  logic signed [4:0] a_i,
  input  logic signed [4:0] b_i,
  output logic signed [9:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module neuron_mac_ctrl #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      relu_en,
  input  logic [5*N_INPUTS-1:0]     x_vec,
  input  logic [5*N_INPUTS-1:0]     w_vec,
  input  logic signed [9:0]         bias,
  output logic                      busy,
  output logic                      done,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic signed [9:0]         y,
  output logic                      sat
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(511);
  localparam logic signed [ACC_W-1:0] Y_MIN = -ACC_W'(512);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q;
  logic [5*N_INPUTS-1:0]      x_q, w_q;
  logic                       relu_q;
  logic [IDX_W-1:0]           idx_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [9:0]          p_q;
  logic                       p_vld_q;
  logic                       busy_q, done_q, sat_q;
  logic signed [ACC_W-1:0]    acc_out_q;
  logic signed [9:0]          y_q;

  logic signed [4:0]          mx, mw;
  logic signed [9:0]          prod_d;
  logic signed [ACC_W-1:0]    p_ext;
  logic signed [ACC_W-1:0]    acc_sum_d;

  // Out-of-range detection for the Q2.8 output.
  function automatic logic is_sat(input logic signed [ACC_W-1:0] a);
    return (a > Y_MAX) || (a < Y_MIN);
  endfunction

  // Clamp to [-512, 511], then optionally clip negatives to zero.
  function automatic logic signed [9:0] clamp_relu(input logic signed [ACC_W-1:0] a,
                                                   input logic relu);
    logic signed [9:0] r;
    if (a > Y_MAX)      r = 10'sd511;
    else if (a < Y_MIN) r = -10'sd512;
    else                r = a[9:0];
    if (relu && r < 0)  r = '0;
    return r;
  endfunction

  // Select the current operand pair from the latched vectors.
  always_comb begin
    mx = '0;
    mw = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        mx = x_q[5*i +: 5];
        mw = w_q[5*i +: 5];
      end
    end
  end

  twosmult u_mult (
    .a_i (mx),
    .b_i (mw),
    .p_o (prod_d)
  );

  // Registered product sign-extended and added; multiplier is never in this path.
  always_comb begin
    p_ext     = {{(ACC_W-10){p_q[9]}}, p_q};
    acc_sum_d = acc_q + p_ext;
  end

  // Control FSM together with the accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_out_q <= '0;
      y_q       <= '0;
      sat_q     <= 1'b0;
      idx_q     <= '0;
      p_vld_q   <= 1'b0;
      acc_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_vec;
            w_q     <= w_vec;
            relu_q  <= relu_en;
            acc_q   <= {{(ACC_W-10){bias[9]}}, bias};
            idx_q   <= '0;
            p_vld_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          p_q     <= prod_d;
          p_vld_q <= 1'b1;
          if (p_vld_q) acc_q <= acc_sum_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_W'(N_INPUTS-1)) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          acc_q     <= acc_sum_d;
          acc_out_q <= acc_sum_d;
          y_q       <= clamp_relu(acc_sum_d, relu_q);
          sat_q     <= is_sat(acc_sum_d);
          p_vld_q   <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign acc_out = acc_out_q;
  assign y       = y_q;
  assign sat     = sat_q;

endmodule

// File: doc/neuron_mac_ctrl.md
# neuron_mac_ctrl

Sequential multiply-accumulate controller for one neuron. It time-shares a single internal `twosmult` instance (5-bit × 5-bit signed → 10-bit signed) across `N_INPUTS` input/weight pairs. It adds a bias, then produces a saturated, optionally ReLU-clipped neuron output. It sits between the layer scheduler and the activation/output registers, and is the only block that drives the multiplier operands.

## Interface
- `N_INPUTS`, default 4: number of input/weight pairs per neuron; valid range ≥ 1.
- `ACC_W`, default 13: accumulator width; must be ≥ 10 + ceil(log2(N_INPUTS+1)).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a neuron evaluation; sampled only in IDLE.
- `relu_en` input 1: when 1, negative results clip to 0; sampled with `start`.
- `x_vec` input 5*N_INPUTS: inputs, Q1.4 signed; element i is bits [5i+4:5i].
- `w_vec` input 5*N_INPUTS: weights, Q1.4 signed, same packing as `x_vec`.
- `bias` input 10: bias, Q2.8 signed.
- `busy` output 1: high from the cycle after `start` is accepted until DONE ends.
- `done` output 1: one-cycle pulse; `acc_out`, `y` and `sat` are valid from this cycle.
- `acc_out` output ACC_W: full-precision signed sum, Q(ACC_W-8).8.
- `y` output 10: final neuron output, Q2.8 signed.
- `sat` output 1: high if `acc_out` fell outside [-512, 511].

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - On `start`=1, register `x_vec`, `w_vec`, `relu_en`.
  - Load the accumulator with `bias` sign-extended to ACC_W.
  - Set `idx`=0, clear `p_valid`, go to RUN.
- **RUN:**
  - Multiplier operands are `x[idx]` and `w[idx]` from the registered copies.
  - The 10-bit product is registered into `p_reg`, and `p_valid` is set.
  - If `p_valid`, `acc += sext(p_reg)`.
  - `idx` increments each cycle. When `idx`==N_INPUTS-1, go to DRAIN.
- **DRAIN:** `acc += sext(p_reg)` for the last product, clear `p_valid`, go to DONE.
- **DONE:**
  - `done`=1 for exactly this cycle.
  - `acc_out` = `acc`.
  - `sat` = (acc > 511) or (acc < -512).
  - `y` = clamp(acc, -512, 511). If the latched `relu_en`=1 and the clamped value is < 0, `y` = 0.
  - Go to IDLE.
- **Outputs:** `acc_out`, `y` and `sat` are registered. They hold their values after DONE until the next DONE or `rst`.
- **Arithmetic:**
  - All arithmetic is two's complement.
  - Product scale is Q2.8, so no shifting is needed before adding to the bias.
  - Accumulation never wraps when ACC_W meets the minimum.
- **`start` while busy:** ignored, with no queuing. The inputs do not need to be held stable after the accepting cycle.
- **`start` in the DONE cycle:** ignored. A new evaluation is accepted only from IDLE.
- **`rst`:** takes priority over everything and can be asserted in any state, including mid-RUN.
  - State goes to IDLE.
  - `busy`=0, `done`=0, `acc_out`=0, `y`=0, `sat`=0, `idx`=0, `p_valid`=0.
  - The accumulator is cleared and no `done` pulse is produced.

## Timing
- `start` sampled at edge T. RUN occupies cycles T+1 … T+N_INPUTS, DRAIN is T+N_INPUTS+1, DONE/`done` is T+N_INPUTS+2.
- Latency from the accepting edge to `done` is N_INPUTS+2 cycles; 6 for the default.
- `busy`=1 from T+1 through T+N_INPUTS+2 inclusive, and 0 in IDLE.
- Back-to-back throughput: the earliest next accepted `start` is one cycle after DONE, giving one neuron every N_INPUTS+3 cycles.
- Edge case N_INPUTS=1: RUN lasts one cycle, then DRAIN, then DONE.
- The combinational path is one `twosmult` evaluation into `p_reg`. The adder path is `p_reg` into `acc`; the multiplier and adder are never chained in one cycle.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → all outputs 0, `busy`=0. Then `start` with all-zero vectors and `bias`=0 → `done` 6 cycles after acceptance, `acc_out`=0, `y`=0.
- **Positive saturation:** all x=01111, all w=01111, `bias`=0 → each product 225, `acc_out`=900, `sat`=1, `y`=511 (0111111111).
- **Mixed signs:**
  - x={01000,11110,01000,00000}, w={10010,01000,11110,01111}, `bias`=16 → products -112, -16, -16, 0.
  - With `relu_en`=0 → `acc_out`=-128, `y`=1110000000, `sat`=0.
  - Rerun with `relu_en`=1 → `y`=0.
- **Busy protection:** pulse `start` again at T+2 and T+N_INPUTS+2 with different vectors → ignored. Exactly one `done`, carrying the result of the first vectors.
- **Reset mid-operation:** assert `rst` during RUN cycle T+2 → no `done`, outputs 0. The next `start` gives a correct fresh result with no residue from the aborted run.
- **Back-to-back:** `start` held high continuously → `done` pulses every 7 cycles, each with correct `y`; inputs change between runs.
